dot_product_arbiter: RTL and testbench
======================================

Name: dot_product_arbiter

Overview:
- Shares a single dot_product engine between NUM_REQ independent requesters, e.g. several mmmul-style sequencers or layer controllers in the ANN datapath.
- Grants the engine round-robin and latches the winner's operand vectors so they stay stable for the whole computation.
- Sequences the engine's reset/done protocol, then returns the 32-bit result to the winning requester with a one-cycle valid pulse.
- Aborts with an error response if the engine does not finish within a cycle budget.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VECTOR_LEN, 4, operand vector length passed to the engine.
- TIMEOUT_CYCLES, 256, maximum cycles in RUN before abort.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_vec1  in  [NUM_REQ][VECTOR_LEN] x 32  per-requester operand 1.
- req_vec2  in  [NUM_REQ][VECTOR_LEN] x 32  per-requester operand 2.
- grant  out  NUM_REQ  one-hot; the requester currently owning the engine.
- resp_valid  out  NUM_REQ  one-cycle pulse to the owner when its result is ready.
- resp_data  out  32  result (opaque 32-bit word), valid with resp_valid.
- resp_err  out  1  qualifies resp_valid; 1 means timeout and resp_data = 0.
- busy  out  1  high in any state other than IDLE.
- eng_rst  out  1  reset to the engine.
- eng_vec1  out  [VECTOR_LEN] x 32  latched operand 1.
- eng_vec2  out  [VECTOR_LEN] x 32  latched operand 2.
- eng_done  in  1  engine done; once high, stays high until eng_rst.
- eng_result  in  32  engine result, valid while eng_done is high.

Behaviour:
- Reset values (rst is synchronous, active-high):
  - grant=0, resp_valid=0, resp_data=0, resp_err=0, busy=0.
  - eng_rst=1, eng_vec1/eng_vec2=0.
  - RR pointer=0, timeout counter=0, state=IDLE.
- States: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - eng_rst=1.
  - If any req bit is set, pick the winner: the first set bit scanning upward from the RR pointer, wrapping modulo NUM_REQ.
  - Register grant=onehot(winner), latch req_vec1/req_vec2[winner] into eng_vec1/eng_vec2, go to LAUNCH.
- LAUNCH:
  - Lasts exactly one cycle; eng_rst stays 1 with stable operands.
  - Guarantees the engine sees at least one reset cycle with the new vectors. Go to RUN.
- RUN:
  - eng_rst=0; timeout counter increments each cycle.
  - If eng_done=1: capture resp_data=eng_result, resp_err=0, go to RESP.
  - Else if counter reaches TIMEOUT_CYCLES-1: resp_data=0, resp_err=1, go to RESP.
- RESP:
  - resp_valid[winner]=1 for exactly one cycle; eng_rst=1.
  - Clear counter and grant; RR pointer = winner+1 mod NUM_REQ; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle T: grant and LAUNCH at T+1, RUN from T+2.
  - If eng_done is first seen at T+2+k, resp_valid is high at T+3+k.
  - Back-to-back arbitration can happen no earlier than the cycle after RESP; minimum spacing between grants is 4 cycles + engine time.
- Handshake rules:
  - Requesters hold req high until their resp_valid, then must drop req the next cycle or it counts as a new request.
  - Operands are sampled only at grant; later changes do not affect the current job.
- Boundary conditions:
  - A req that drops while its job is in flight does not abort the job; the response is still issued.
  - eng_done high in the first RUN cycle is accepted; eng_done high during LAUNCH/IDLE is ignored.
  - eng_done and timeout in the same cycle: done wins, resp_err=0.
  - Simultaneous requests: fairness follows the RR pointer; a continuously requesting port is served at least once every NUM_REQ grants.
  - Pointer wrap-around: winner NUM_REQ-1 sets the pointer to 0.
  - rst mid-operation: immediate return to reset values next edge; eng_rst=1; no resp_valid is issued for the aborted job.
- Invariants:
  - grant and resp_valid are each one-hot or zero.
  - resp_valid is asserted only for the bit set in grant during that job.

Test Plan:
- Single requester: req=0001, vectors [1,2,3,4]·[1,1,1,1] with a model engine done 4 cycles after eng_rst falls -> grant=0001 next cycle, resp_valid=0001 one cycle with resp_data=10, resp_err=0, busy falls after.
- All four requesting continuously from reset -> grants in order 0001, 0010, 0100, 1000, 0001; each port gets exactly one resp_valid per round.
- Pointer at 2, requests 0011 -> port 0 granted (wrap), then port 1.
- Engine never asserts done, TIMEOUT_CYCLES=16 -> resp_valid after 16 RUN cycles, resp_err=1, resp_data=0; next request proceeds normally.
- Change req_vec1 of the owner during RUN -> eng_vec1 unchanged, result matches the originally latched vectors.
- Assert rst for 1 cycle during RUN -> grant=0, eng_rst=1, no resp_valid; a re-issued request completes correctly.

Source files
------------

// File: rtl/dot_product_arbiter.sv
// dot_product_arbiter: round-robin sharing of one dot_product engine
// between NUM_REQ requesters, with operand latching and a run timeout.
module dot_product_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int VECTOR_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req,
    input  logic [NUM_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec1,
    input  logic [NUM_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec2,
    output logic [NUM_REQ-1:0]                       grant,
    output logic [NUM_REQ-1:0]                       resp_valid,
    output logic [31:0]                              resp_data,
    output logic                                     resp_err,
    output logic                                     busy,
    output logic                                     eng_rst,
    output logic [VECTOR_LEN-1:0][31:0]              eng_vec1,
    output logic [VECTOR_LEN-1:0][31:0]              eng_vec2,
    input  logic                                     eng_done,
    input  logic [31:0]                              eng_result
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        RESP
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] win;
    logic [CW-1:0] cnt;
    logic          any;
    int            idx;

    // Scan downward in offset so the lowest offset from ptr wins last.
    always_comb begin
        win = ptr;
        any = 1'b0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[PW'(idx)]) begin
                win = PW'(idx);
                any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            eng_rst    <= 1'b1;
            eng_vec1   <= '0;
            eng_vec2   <= '0;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
        end else begin
            resp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        owner    <= win;
                        grant    <= NUM_REQ'(1) << win;
                        eng_vec1 <= req_vec1[win];
                        eng_vec2 <= req_vec2[win];
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                // Engine stays in reset one cycle with the new operands.
                LAUNCH: begin
                    eng_rst <= 1'b0;
                    cnt     <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (eng_done || cnt == CMAX) begin
                        resp_data  <= eng_done ? eng_result : '0;
                        resp_err   <= !eng_done;
                        resp_valid <= grant;
                        eng_rst    <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    ptr   <= (owner == LAST) ? '0 : owner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_arbiter.sv
// tb_dot_product_arbiter: directed and random checks of dot_product_arbiter
// against a job-schedule model and a behavioural engine.
module tb_dot_product_arbiter;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int TO = 16;
    localparam int VW = L * 32;

    typedef logic [L-1:0][31:0] vec_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             req;
    logic [N-1:0][L-1:0][31:0] v1;
    logic [N-1:0][L-1:0][31:0] v2;
    logic [N-1:0]             grant;
    logic [N-1:0]             resp_valid;
    logic [31:0]              resp_data;
    logic                     resp_err;
    logic                     busy;
    logic                     eng_rst;
    vec_t                     eng_vec1;
    vec_t                     eng_vec2;
    logic                     eng_done;
    logic [31:0]              eng_result;

    always #5 clk = ~clk;

    dot_product_arbiter #(
        .NUM_REQ(N),
        .VECTOR_LEN(L),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_vec1(v1),
        .req_vec2(v2),
        .grant(grant),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_err(resp_err),
        .busy(busy),
        .eng_rst(eng_rst),
        .eng_vec1(eng_vec1),
        .eng_vec2(eng_vec2),
        .eng_done(eng_done),
        .eng_result(eng_result)
    );

    function automatic logic [31:0] dot(vec_t a, vec_t b);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < L; i++) s += a[i] * b[i];
        return s;
    endfunction

    // Engine: done once `lat` cycles out of reset, or forced high.
    int   lat = 4;
    logic force_done = 1'b0;
    int   ecnt = 0;
    always @(posedge clk) ecnt <= eng_rst ? 0 : ecnt + 1;
    assign eng_done   = force_done | (!eng_rst && ecnt >= lat);
    assign eng_result = dot(eng_vec1, eng_vec2);

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Job-schedule model
    logic         job = 1'b0;
    int           js = 0;
    int           jr = -1;
    int           jw = 0;
    int           mptr = 0;
    logic         jerr = 1'b0;
    logic [31:0]  jdata = '0;
    logic [N-1:0] jg = '0;

    logic [N-1:0] e_grant, e_rv;
    logic         e_busy, e_erst, e_err;
    logic [31:0]  e_data;
    vec_t         e_v1, e_v2;

    int gord[$];
    int rcount[N];

    function automatic int pick(logic [N-1:0] r, int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic int gget(int k);
        return (k < gord.size()) ? gord[k] : -1;
    endfunction

    task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected outputs for cycle cyc+1 given the inputs of cycle cyc.
    task automatic predict();
        int n;
        int d;
        n = cyc + 1;
        if (rst) begin
            job  = 1'b0;
            mptr = 0;
            jr   = -1;
            e_v1 = '0;
            e_v2 = '0;
            e_data = '0;
            e_err  = 1'b0;
        end else begin
            if (job && cyc == jr) begin
                job  = 1'b0;
                mptr = (jw + 1) % N;
            end
            if (!job && cyc > jr && req != 0) begin
                jw    = pick(req, mptr);
                jg    = '0;
                jg[jw] = 1'b1;
                js    = cyc;
                d     = force_done ? 0 : lat;
                jerr  = d > TO - 1;
                jr    = cyc + 3 + (jerr ? TO - 1 : d);
                jdata = jerr ? 32'd0 : dot(v1[jw], v2[jw]);
                e_v1  = v1[jw];
                e_v2  = v2[jw];
                job   = 1'b1;
            end
        end
        e_grant = job ? jg : '0;
        e_busy  = job;
        e_rv    = (job && n == jr) ? jg : '0;
        e_erst  = !(job && n >= js + 2 && n <= jr - 1);
        e_data  = jdata;
        e_err   = jerr;
    endtask

    task automatic compare();
        chk("grant", grant, e_grant);
        chk("resp_valid", resp_valid, e_rv);
        chk("busy", busy, e_busy);
        chk("eng_rst", eng_rst, e_erst);
        chk("eng_vec1", eng_vec1, e_v1);
        chk("eng_vec2", eng_vec2, e_v2);
        if (e_rv != 0) begin
            chk("resp_data", resp_data, e_data);
            chk("resp_err", resp_err, e_err);
        end
    endtask

    task automatic run_cycle();
        predict();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic randomize_vecs();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < L; k++) begin
                v1[i][k] = $urandom;
                v2[i][k] = $urandom;
            end
    endtask

    task automatic drain();
        req = '0;
        repeat (40) run_cycle();
        force_done = 1'b0;
    endtask

    // One job from idle; operands scrambled once the grant is seen.
    task automatic single_job(input logic [N-1:0] r, input int l,
                              input logic f, output int gl, output int lt,
                              output logic [31:0] d, output logic e,
                              output logic [N-1:0] rv);
        int t0;
        req = r;
        lat = l;
        force_done = f;
        t0 = cyc;
        gl = -1;
        lt = -1;
        d = '0;
        e = 1'b0;
        rv = '0;
        for (int k = 0; k < 60 && lt < 0; k++) begin
            run_cycle();
            if (grant != 0 && gl < 0) begin
                gl = cyc - t0;
                randomize_vecs();
            end
            if (resp_valid != 0) begin
                lt = cyc - t0;
                d = resp_data;
                e = resp_err;
                rv = resp_valid;
                req = '0;
            end
        end
        run_cycle();
        force_done = 1'b0;
    endtask

    task automatic observe(int ncyc, int ngr, logic drop);
        logic [N-1:0] pg;
        pg = grant;
        for (int k = 0; k < ncyc && gord.size() < ngr; k++) begin
            run_cycle();
            if (grant != 0 && pg == 0) gord.push_back(int'(grant));
            for (int i = 0; i < N; i++)
                if (resp_valid[i]) begin
                    rcount[i]++;
                    if (drop) req[i] = 1'b0;
                end
            pg = grant;
        end
    endtask

    int           gl, lt, nresp;
    logic [31:0]  rd;
    logic         re;
    logic [N-1:0] rv;

    initial begin
        rst = 1'b1;
        req = '0;
        v1 = '0;
        v2 = '0;
        repeat (3) run_cycle();
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_eng_rst", eng_rst, 1'b1);
        chk("rst_resp_data", resp_data, '0);

        // Single requester, [1,2,3,4].[1,1,1,1]
        rst = 1'b0;
        run_cycle();
        v1[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        v2[0] = {32'd1, 32'd1, 32'd1, 32'd1};
        single_job(4'b0001, 4, 1'b0, gl, lt, rd, re, rv);
        chk("b_grant_lat", gl, 1);
        chk("b_resp_lat", lt, 7);
        chk("b_rv", rv, 4'b0001);
        chk("b_data", rd, 32'd10);
        chk("b_err", re, 1'b0);
        chk("b_busy_after", busy, 1'b0);

        // All four requesting continuously from reset
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        lat = 2;
        req = '1;
        gord.delete();
        foreach (rcount[i]) rcount[i] = 0;
        observe(200, 5, 1'b0);
        chk("c_g0", gget(0), 1);
        chk("c_g1", gget(1), 2);
        chk("c_g2", gget(2), 4);
        chk("c_g3", gget(3), 8);
        chk("c_g4", gget(4), 1);
        for (int i = 0; i < N; i++) chk("c_resp_per_port", rcount[i], 1);
        drain();

        // Pointer at 2, requests 0011 wrap to port 0 then port 1
        single_job(4'b0010, 1, 1'b0, gl, lt, rd, re, rv);
        chk("d_setup_rv", rv, 4'b0010);
        randomize_vecs();
        req = 4'b0011;
        lat = 3;
        gord.delete();
        observe(100, 2, 1'b1);
        chk("d_g0", gget(0), 1);
        chk("d_g1", gget(1), 2);
        drain();

        // Timeout, then a normal job
        single_job(4'b0100, 1000, 1'b0, gl, lt, rd, re, rv);
        chk("e_to_lat", lt, 18);
        chk("e_to_err", re, 1'b1);
        chk("e_to_data", rd, '0);
        chk("e_to_rv", rv, 4'b0100);
        single_job(4'b0100, 3, 1'b0, gl, lt, rd, re, rv);
        chk("e_next_lat", lt, 6);
        chk("e_next_err", re, 1'b0);

        // Done coincides with the last allowed cycle: done wins
        single_job(4'b0001, TO - 1, 1'b0, gl, lt, rd, re, rv);
        chk("f_lat", lt, 18);
        chk("f_err", re, 1'b0);

        // Done high already in IDLE/LAUNCH: taken in first RUN cycle
        single_job(4'b1000, 1000, 1'b1, gl, lt, rd, re, rv);
        chk("g_lat", lt, 3);
        chk("g_err", re, 1'b0);

        // Reset during RUN aborts silently
        req = 4'b1000;
        lat = 10;
        repeat (4) run_cycle();
        rst = 1'b1;
        req = '0;
        run_cycle();
        chk("h_grant", grant, '0);
        chk("h_eng_rst", eng_rst, 1'b1);
        chk("h_busy", busy, 1'b0);
        rst = 1'b0;
        nresp = 0;
        repeat (20) begin
            run_cycle();
            if (resp_valid != 0) nresp++;
        end
        chk("h_no_resp", nresp, 0);
        single_job(4'b1000, 2, 1'b0, gl, lt, rd, re, rv);
        chk("h_retry_lat", lt, 5);
        chk("h_retry_rv", rv, 4'b1000);
        chk("h_retry_err", re, 1'b0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            run_cycle();
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i]) req[i] = 1'b0;
                else if (!req[i]) req[i] = ($urandom_range(3) == 0);
                else if ($urandom_range(63) == 0) req[i] = 1'b0;
            end
            randomize_vecs();
            if (!job) begin
                lat = ($urandom_range(7) == 0) ? 1000 : int'($urandom_range(20));
                force_done = ($urandom_range(7) == 0);
            end
            rst = ($urandom_range(499) == 0);
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
